// File: rtl/cpu_txn_pkg.sv
// Shared defaults and payload type for the CPU-to-client transaction path.
package cpu_txn_pkg;
    localparam int unsigned DEFAULT_DEPTH      = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH = 64;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] txn_data_t;
endpackage

// File: rtl/multisim_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and an occupancy count.
// Full/empty come from the count, so pointers need no extra wrap bit.
module multisim_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned LVL_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [LVL_W-1:0]      level_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is left uninitialised on reset; the count gates what is visible.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/cpu_txn_buffer.sv
// Elastic buffer between the cpu source and the multisim client, with
// delivered-word counting and a drain-qualified done indication.
module cpu_txn_buffer
    import cpu_txn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned CNT_WIDTH  = 32,
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_done,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_done,
    output logic [LVL_W-1:0]      level,
    output logic [CNT_WIDTH-1:0]  sent_count,
    output logic                  proto_err
);
    logic                 full, empty, push, pop;
    logic                 done_seen_q, done_seen_d;
    logic                 out_done_q, out_done_d;
    logic                 proto_err_q, proto_err_d;
    logic [CNT_WIDTH-1:0] sent_count_q, sent_count_d;

    // Ready depends on occupancy only, so a pop never frees a slot same-cycle.
    assign in_rdy  = !full;
    assign out_vld = !empty;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    multisim_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (in_data),
        .rd_data_o (out_data),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level)
    );

    always_comb begin
        done_seen_d  = done_seen_q | in_done;
        proto_err_d  = proto_err_q | (push && done_seen_q);
        sent_count_d = sent_count_q;
        if (pop && (sent_count_q != '1)) sent_count_d = sent_count_q + CNT_WIDTH'(1);
        // Done only once the buffer sat empty for a whole cycle with nothing arriving.
        out_done_d   = out_done_q | (done_seen_d && empty && !push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_seen_q  <= 1'b0;
            out_done_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            sent_count_q <= '0;
        end else begin
            done_seen_q  <= done_seen_d;
            out_done_q   <= out_done_d;
            proto_err_q  <= proto_err_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign out_done   = out_done_q;
    assign proto_err  = proto_err_q;
    assign sent_count = sent_count_q;
endmodule

// File: tb/tb_cpu_txn_buffer.sv
// Scoreboard bench for cpu_txn_buffer: accepted pushes queue expected words,
// a negedge monitor pops and compares every delivered word.
module tb_cpu_txn_buffer;
    import cpu_txn_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0, in_done = 1'b0, out_rdy = 1'b0;
    txn_data_t   in_data = '0;
    logic        in_rdy, out_vld, out_done, proto_err;
    txn_data_t   out_data;
    logic [3:0]  level;
    logic [31:0] sent_count;

    int n_cmp = 0;
    int n_err = 0;
    txn_data_t exp_q[$];
    bit rand_rdy_stop;

    always #5 clk = ~clk;

    cpu_txn_buffer dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_done(in_done), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_done(out_done), .level(level), .sent_count(sent_count), .proto_err(proto_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_word: got %0h with empty scoreboard", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input txn_data_t d);
        in_vld = 1'b1;
        in_data = d;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_rdy) break;
            if (n > 300) begin
                n_cmp++; n_err++;
                $display("FAIL push_timeout: data %0h never accepted", d);
                @(posedge clk); #1 in_vld = 1'b0;
                return;
            end
        end
        exp_q.push_back(d);
        @(posedge clk); #1 in_vld = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (level == 0 && exp_q.size() == 0) break;
            if (n > 1000) begin
                n_cmp++; n_err++;
                $display("FAIL drain_timeout: level %0d queued %0d", level, exp_q.size());
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_vld = 1'b0; in_done = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_level", level, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_out_done", out_done, 0);
        chk("rst_proto_err", proto_err, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_rdy", in_rdy, 1);

        // Single word round trip
        out_rdy = 1'b1;
        push(64'hDEAD_BEEF);
        chk("t1_out_vld", out_vld, 1);
        chk("t1_level1", level, 1);
        @(posedge clk); #1;
        chk("t1_level0", level, 0);
        chk("t1_sent", sent_count, 1);

        // Overfill with client stalled
        out_rdy = 1'b0;
        fork
            for (int i = 1; i <= 10; i++) push(64'(i));
        join_none
        repeat (12) @(negedge clk);
        chk("t2_level_full", level, 8);
        chk("t2_in_rdy", in_rdy, 0);
        chk("t2_src_stalled", in_vld, 1);
        chk("t2_sb_depth", exp_q.size(), 8);
        @(posedge clk); #1 out_rdy = 1'b1;
        wait fork;
        drain();
        chk("t2_sent", sent_count, 11);

        // Full buffer, pop and push offered together
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) push(64'h100 + 64'(i));
        out_rdy = 1'b1; in_vld = 1'b1; in_data = 64'h200;
        @(negedge clk);
        chk("t3_no_push_full", in_rdy, 0);
        @(posedge clk); #1;
        chk("t3_level7", level, 7);
        chk("t3_rdy_again", in_rdy, 1);
        @(negedge clk);
        if (in_rdy) exp_q.push_back(64'h200);
        @(posedge clk); #1 in_vld = 1'b0;
        chk("t3_level_pushpop", level, 7);
        drain();

        // Random stream of 100 words
        do_reset();
        rand_rdy_stop = 1'b0;
        fork
            while (!rand_rdy_stop) begin
                @(posedge clk); #1;
                if (!rand_rdy_stop) out_rdy = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
            push(64'h5000 + 64'(i));
        end
        in_done = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (level == 0) break;
            if (n > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL stream_timeout: level %0d", level);
                break;
            end
        end
        chk("t4_done_not_early", out_done, 0);
        @(negedge clk);
        chk("t4_done", out_done, 1);
        chk("t4_sent", sent_count, 100);
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_no_err", proto_err, 0);
        rand_rdy_stop = 1'b1;
        @(posedge clk); #1 out_rdy = 1'b1;
        @(posedge clk); #1;

        // Push after done
        do_reset();
        out_rdy = 1'b0;
        push(64'hA1);
        in_done = 1'b1;
        @(posedge clk); #1;
        chk("t5_err_clear", proto_err, 0);
        push(64'hB2);
        chk("t5_err_set", proto_err, 1);
        chk("t5_done_held", out_done, 0);
        out_rdy = 1'b1;
        drain();
        chk("t5_done_after", out_done, 1);
        chk("t5_err_sticky", proto_err, 1);
        chk("t5_sent", sent_count, 2);

        // Reset mid-stream
        in_done = 1'b0;
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push(64'h700 + 64'(i));
        chk("t6_level5", level, 5);
        rst = 1'b1;
        #1;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_vld", out_vld, 0);
        chk("t6_rst_sent", sent_count, 0);
        chk("t6_rst_err", proto_err, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        out_rdy = 1'b1;
        push(64'hCAFE);
        drain();
        chk("t6_sent", sent_count, 1);
        chk("t6_done_clear", out_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #90000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
